// File: rtl/call_switchboard_pkg.sv
// rtl/call_switchboard_pkg.sv - call switchboard state encoding and shared constants
package call_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_TALK    = 2'd2,
    ST_CLEANUP = 2'd3
  } call_state_t;

  // talk_cycles saturates here instead of wrapping, so billing never undercounts
  localparam logic [15:0] TALK_SAT = 16'hFFFF;

  // Width of a handset index; at least one bit even for a single handset
  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/call_switchboard_if.sv
// rtl/call_switchboard_if.sv - handset-side and channel-side signals of the switchboard
interface call_switchboard_if import call_pkg::*; #(
  parameter int N = 4
);
  localparam int IDW = idw_of(N);

  logic [N-1:0]     req;
  logic [N*IDW-1:0] dial_id;
  logic [N-1:0]     answer;
  logic [N-1:0]     hangup;
  logic [N-1:0]     grant;
  logic [N-1:0]     ring;
  logic [N-1:0]     busy_tone;
  logic             start_call;
  logic             answer_call;
  logic             end_call;
  logic             call_active;
  logic [15:0]      talk_cycles;

  modport master (
    output req, dial_id, answer, hangup,
    input  grant, ring, busy_tone, start_call, answer_call, end_call,
    input  call_active, talk_cycles
  );

  modport slave (
    input  req, dial_id, answer, hangup,
    output grant, ring, busy_tone, start_call, answer_call, end_call,
    output call_active, talk_cycles
  );

endinterface

// File: rtl/call_switchboard_rr_arbiter.sv
// rtl/call_switchboard_rr_arbiter.sv - combinational round-robin picker for handset requests
module rr_arbiter import call_pkg::*; #(
  parameter int N   = 4,
  parameter int IDW = idw_of(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           valid
);

  logic [IDW-1:0] pos;

  // Scan the N positions following ptr in wrap-around order; the first requester wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IDW'((int'(ptr) + k) % N);
      if (!valid && req[pos]) begin
        valid    = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/call_switchboard.sv
// rtl/call_switchboard.sv - shared-channel exchange controller; CALL_LIMIT_EN caps talk time at MAX_TALK
module call_switchboard import call_pkg::*; #(
  parameter int N_PHONES     = 4,
  parameter int RING_TIMEOUT = 10,
  parameter int MAX_TALK     = 200
) (
  input logic               clk,
  input logic               rst,
  call_switchboard_if.slave bus
);

  localparam int IDW = idw_of(N_PHONES);

  call_state_t          state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       caller_q, caller_d;
  logic [IDW-1:0]       callee_q, callee_d;
  logic [15:0]          ring_cnt_q, ring_cnt_d;
  logic [15:0]          talk_q, talk_d;
  logic [N_PHONES-1:0]  grant_q, grant_d;
  logic [N_PHONES-1:0]  ring_q, ring_d;
  logic [N_PHONES-1:0]  busy_q, busy_d;
  logic                 start_q, start_d;
  logic                 answer_q, answer_d;
  logic                 end_q, end_d;
  logic                 active_q, active_d;

  logic [N_PHONES-1:0]  arb_gnt;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_valid;
  logic [IDW-1:0]       dial_sel;
  logic                 callee_bad;
  logic [15:0]          talk_inc;
  logic                 limit_hit;

  rr_arbiter #(
    .N   (N_PHONES),
    .IDW (IDW)
  ) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign dial_sel   = bus.dial_id[int'(arb_idx)*IDW +: IDW];
  // A call cannot be placed to yourself, to a nonexistent handset, or to one that is off-hook
  assign callee_bad = (dial_sel == arb_idx) || (int'(dial_sel) >= N_PHONES) || bus.req[dial_sel];
  assign talk_inc   = (talk_q == TALK_SAT) ? talk_q : talk_q + 16'd1;

`ifdef CALL_LIMIT_EN
  assign limit_hit = (talk_inc == 16'(MAX_TALK));
`else
  logic unused_max_talk;
  assign unused_max_talk = ^16'(MAX_TALK);
  assign limit_hit       = 1'b0;
`endif

  // Next state and next value of every registered output; pulses default low
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    caller_d   = caller_q;
    callee_d   = callee_q;
    ring_cnt_d = ring_cnt_q;
    talk_d     = talk_q;
    grant_d    = grant_q;
    ring_d     = ring_q;
    active_d   = active_q;
    busy_d     = '0;
    start_d    = 1'b0;
    answer_d   = 1'b0;
    end_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          if (callee_bad) begin
            busy_d[arb_idx] = 1'b1;
            rr_ptr_d        = arb_idx;
          end else begin
            caller_d         = arb_idx;
            callee_d         = dial_sel;
            grant_d          = arb_gnt;
            ring_d           = '0;
            ring_d[dial_sel] = 1'b1;
            start_d          = 1'b1;
            ring_cnt_d       = '0;
            state_d          = ST_RINGING;
          end
        end
      end
      ST_RINGING: begin
        if (bus.hangup[caller_q] || ring_cnt_q == 16'(RING_TIMEOUT - 1)) begin
          end_d   = 1'b1;
          state_d = ST_CLEANUP;
        end else if (bus.answer[callee_q]) begin
          answer_d = 1'b1;
          ring_d   = '0;
          active_d = 1'b1;
          talk_d   = '0;
          state_d  = ST_TALK;
        end else begin
          ring_cnt_d = ring_cnt_q + 16'd1;
        end
      end
      ST_TALK: begin
        talk_d = talk_inc;
        if (bus.hangup[caller_q] || bus.hangup[callee_q] || limit_hit) begin
          end_d    = 1'b1;
          active_d = 1'b0;
          state_d  = ST_CLEANUP;
        end
      end
      ST_CLEANUP: begin
        grant_d  = '0;
        ring_d   = '0;
        rr_ptr_d = caller_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any call in progress without an end_call
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= IDW'(N_PHONES - 1);
      caller_q   <= '0;
      callee_q   <= '0;
      ring_cnt_q <= '0;
      talk_q     <= '0;
      grant_q    <= '0;
      ring_q     <= '0;
      busy_q     <= '0;
      start_q    <= 1'b0;
      answer_q   <= 1'b0;
      end_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      caller_q   <= caller_d;
      callee_q   <= callee_d;
      ring_cnt_q <= ring_cnt_d;
      talk_q     <= talk_d;
      grant_q    <= grant_d;
      ring_q     <= ring_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      answer_q   <= answer_d;
      end_q      <= end_d;
      active_q   <= active_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.ring        = ring_q;
  assign bus.busy_tone   = busy_q;
  assign bus.start_call  = start_q;
  assign bus.answer_call = answer_q;
  assign bus.end_call    = end_q;
  assign bus.call_active = active_q;
  assign bus.talk_cycles = talk_q;

endmodule

// File: tb/tb_call_switchboard.sv
// tb/tb_call_switchboard.sv - randomized and directed self-checking bench for call_switchboard
module tb_call_switchboard;
  import call_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int RT  = 10;
  localparam int MT  = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  call_switchboard_if #(.N(N)) bus ();

  call_switchboard #(
    .N_PHONES     (N),
    .RING_TIMEOUT (RT),
    .MAX_TALK     (MT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who is calling whom, and how long the call has been in each phase
  int             m_phase;   // 0 idle, 1 ringing, 2 talking, 3 tidy-up cycle
  int             m_ptr, m_c, m_e, m_age;
  logic [N-1:0]   e_grant, e_ring, e_busy;
  logic           e_start, e_ans, e_end, e_act;
  logic [15:0]    e_talk;

  function automatic int dial_of(input int p);
    logic [N*IDW-1:0] d;
    d = bus.dial_id;
    return int'(d[p*IDW +: IDW]);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = N - 1; m_c = 0; m_e = 0; m_age = 0;
    e_grant = '0; e_ring = '0; e_busy = '0;
    e_start = 0; e_ans = 0; e_end = 0; e_act = 0; e_talk = '0;
  endtask

  task automatic model_step();
    int c, e;
    logic limit;
    e_busy = '0; e_start = 0; e_ans = 0; e_end = 0;
    case (m_phase)
      0: begin
        c = -1;
        for (int k = 1; k <= N; k++)
          if (c < 0 && bus.req[(m_ptr + k) % N]) c = (m_ptr + k) % N;
        if (c >= 0) begin
          e = dial_of(c);
          if (e == c || e >= N || bus.req[e]) begin
            e_busy[c] = 1'b1;
            m_ptr = c;
          end else begin
            m_c = c; m_e = e;
            e_grant = '0; e_grant[c] = 1'b1;
            e_ring = '0;  e_ring[e] = 1'b1;
            e_start = 1; m_age = 0; m_phase = 1;
          end
        end
      end
      1: begin
        m_age++;
        if (bus.hangup[m_c] || m_age == RT) begin
          e_end = 1; m_phase = 3;
        end else if (bus.answer[m_e]) begin
          e_ans = 1; e_ring = '0; e_act = 1; e_talk = '0; m_phase = 2;
        end
      end
      2: begin
        if (e_talk != 16'hFFFF) e_talk = e_talk + 16'd1;
        limit = 1'b0;
`ifdef CALL_LIMIT_EN
        limit = (e_talk == 16'(MT));
`endif
        if (bus.hangup[m_c] || bus.hangup[m_e] || limit) begin
          e_end = 1; e_act = 0; m_phase = 3;
        end
      end
      default: begin
        e_grant = '0; e_ring = '0; m_ptr = m_c; m_phase = 0;
      end
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Every cycle, outputs must match the model
  always @(negedge clk) begin
    chk("grant",       32'(bus.grant),       32'(e_grant));
    chk("ring",        32'(bus.ring),        32'(e_ring));
    chk("busy_tone",   32'(bus.busy_tone),   32'(e_busy));
    chk("start_call",  32'(bus.start_call),  32'(e_start));
    chk("answer_call", 32'(bus.answer_call), 32'(e_ans));
    chk("end_call",    32'(bus.end_call),    32'(e_end));
    chk("call_active", 32'(bus.call_active), 32'(e_act));
    chk("talk_cycles", 32'(bus.talk_cycles), 32'(e_talk));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_dial(input int p, input int v);
    logic [N*IDW-1:0] d;
    d = bus.dial_id;
    d[p*IDW +: IDW] = IDW'(v);
    bus.dial_id = d;
  endtask

  task automatic wait_start(input string nm);
    int k;
    k = 0;
    while (!bus.start_call && k < 20) begin tick(); k++; end
    chk(nm, 32'(bus.start_call), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, busy1;
    logic [N-1:0] exp_g [4];
    bus.req = '0; bus.dial_id = '0; bus.answer = '0; bus.hangup = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("reset_grant", 32'(bus.grant), 32'd0);
    chk("reset_talk",  32'(bus.talk_cycles), 32'd0);
    chk("reset_active", 32'(bus.call_active), 32'd0);

    // Phone0 calls 2, answered, phone0 hangs up five cycles later
    bus.req[0] = 1'b1; set_dial(0, 2);
    tick();
    wait_start("t1_start");
    chk("t1_grant", 32'(bus.grant), 32'h1);
    chk("t1_ring",  32'(bus.ring),  32'h4);
    bus.req[0] = 1'b0;
    tick(); tick();
    bus.answer[2] = 1'b1;
    tick();
    chk("t1_answer_call", 32'(bus.answer_call), 32'd1);
    bus.answer[2] = 1'b0;
    repeat (4) tick();
    bus.hangup[0] = 1'b1;
    tick();
    chk("t1_end_call", 32'(bus.end_call), 32'd1);
    chk("t1_talk",     32'(bus.talk_cycles), 32'd5);
    bus.hangup[0] = 1'b0;
    tick();
    chk("t1_grant_clear", 32'(bus.grant), 32'd0);

    // Round robin with 1011 held from pointer 0
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0001; exp_g[3] = 4'b0010;
    set_dial(0, 2); set_dial(1, 2); set_dial(3, 2);
    bus.req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      tick();
      wait_start("t2_start");
      chk("t2_grant", 32'(bus.grant), 32'(exp_g[k]));
      bus.hangup = bus.grant;
      tick();
      bus.hangup = '0;
      if (k == 3) bus.req = '0;
      tick();
    end

    // Rejected calls: self, then an off-hook callee
    bus.req = 4'b0010; set_dial(1, 1);
    tick();
    chk("t3_busy_self", 32'(bus.busy_tone), 32'h2);
    chk("t3_grant_self", 32'(bus.grant), 32'd0);
    set_dial(1, 3); set_dial(3, 3); bus.req = 4'b1010;
    busy1 = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.busy_tone[1]) busy1++;
    end
    chk("t3_busy1_count", 32'(busy1), 32'd2);
    chk("t3_grant_busy", 32'(bus.grant), 32'd0);
    bus.req = '0;
    tick();

    // Ring timeout
    bus.req[0] = 1'b1; set_dial(0, 3);
    tick();
    wait_start("t4_start");
    bus.req[0] = 1'b0;
    cnt = 0;
    while (!bus.end_call && cnt < 30) begin tick(); cnt++; end
    chk("t4_timeout_cycles", 32'(cnt), 32'(RT));
    tick();
    chk("t4_ring_drop", 32'(bus.ring), 32'd0);

    // Hangup beats answer in the same cycle
    bus.req[0] = 1'b1; set_dial(0, 3);
    tick();
    wait_start("t5_start");
    bus.req[0] = 1'b0;
    tick();
    bus.hangup[0] = 1'b1; bus.answer[3] = 1'b1;
    tick();
    chk("t5_end",    32'(bus.end_call),    32'd1);
    chk("t5_answer", 32'(bus.answer_call), 32'd0);
    chk("t5_active", 32'(bus.call_active), 32'd0);
    bus.hangup = '0; bus.answer = '0;
    tick();

`ifdef CALL_LIMIT_EN
    bus.req[2] = 1'b1; set_dial(2, 1);
    tick();
    wait_start("t6_start");
    bus.req[2] = 1'b0;
    bus.answer[1] = 1'b1;
    tick();
    bus.answer[1] = 1'b0;
    cnt = 0;
    while (!bus.end_call && cnt < 300) begin tick(); cnt++; end
    chk("t6_limit_talk", 32'(bus.talk_cycles), 32'(MT));
    tick();
`endif

    // Asynchronous reset mid-call
    bus.req[1] = 1'b1; set_dial(1, 0);
    tick();
    wait_start("t7_start");
    bus.req[1] = 1'b0;
    bus.answer[0] = 1'b1;
    tick();
    bus.answer[0] = 1'b0;
    repeat (3) tick();
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("t7_rst_active", 32'(bus.call_active), 32'd0);
    chk("t7_rst_grant",  32'(bus.grant), 32'd0);
    chk("t7_rst_talk",   32'(bus.talk_cycles), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < N; p++) begin
        bus.req[p]    = ($urandom_range(0, 3) == 0);
        bus.answer[p] = ($urandom_range(0, 2) == 0);
        bus.hangup[p] = ($urandom_range(0, 15) == 0);
        set_dial(p, int'($urandom_range(0, N - 1)));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
